// File: rtl/lsu_ctrl_pkg.sv
// Shared width codes, FSM encoding and address helpers for the load/store unit.
// LSU_MISALIGN_TRAP_EN adds the misalignment predicate used by the trap path.
package lsu_ctrl_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

  // Byte lane of the access; halfwords keep addr[1] only, words (and unknown codes) lane 0.
  function automatic logic [1:0] lsu_offset(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      LSU_B, LSU_BU: return addr_lo;
      LSU_H, LSU_HU: return {addr_lo[1], 1'b0};
      default:       return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lsu_be(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      LSU_B, LSU_BU: return 4'b0001 << off;
      LSU_H, LSU_HU: return 4'b0011 << off;
      default:       return 4'b1111;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      LSU_B, LSU_BU: return 1'b0;
      LSU_H, LSU_HU: return addr_lo[0];
      default:       return addr_lo != 2'b00;
    endcase
  endfunction
`endif

endpackage

// File: rtl/lsu_ctrl_load_extend.sv
// Load-data aligner: shifts the selected lane down and sign/zero-extends by width code.
// Purely combinational so the writeback stage can reuse it.
module lsu_ctrl_load_extend
  import lsu_ctrl_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_funct3)
      LSU_B:   o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LSU_H:   o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LSU_BU:  o_data = {24'h0, w_shifted[7:0]};
      LSU_HU:  o_data = {16'h0, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: EX-stage op to data-memory req/gnt/rvalid handshake, extended load writeback.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of forcing alignment.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [4:0]        in_rd,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              misalign_exc,
  output logic [ADDR_W-1:0] misalign_addr,
`endif
  output logic              stall
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("lsu_ctrl: only DATA_W = 32 is supported");
  end

  lsu_state_e r_state, w_state_next;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [1:0]        r_off;
  logic [2:0]        r_funct3;
  logic [4:0]        r_rd;
  logic              r_wb_valid;
  logic [4:0]        r_wb_rd;
  logic [31:0]       r_wb_data;

  logic [1:0]  w_off;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_ext;
  logic        w_accept;
  logic        w_issue;
  logic        w_capture;
  logic        w_misalign;

  assign w_off    = lsu_offset(in_funct3, in_addr[1:0]);
  assign w_accept = (r_state == LSU_IDLE) && in_valid;
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = lsu_misaligned(in_funct3, in_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif
  assign w_issue = w_accept && !w_misalign;

  // A grant carrying rvalid in the same cycle is the response of a zero-latency memory.
  assign w_capture = ((r_state == LSU_REQ) && mem_gnt && !r_we && mem_rvalid) ||
                     ((r_state == LSU_RESP) && mem_rvalid);

  always_comb begin
    w_wdata_rep = in_wdata;
    case (in_funct3)
      LSU_B, LSU_BU: w_wdata_rep = {4{in_wdata[7:0]}};
      LSU_H, LSU_HU: w_wdata_rep = {2{in_wdata[15:0]}};
      default:       w_wdata_rep = in_wdata;
    endcase
  end

  lsu_ctrl_load_extend u_load_extend (
    .i_rdata  (mem_rdata),
    .i_offset (r_off),
    .i_funct3 (r_funct3),
    .o_data   (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LSU_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LSU_IDLE: if (w_issue) w_state_next = LSU_REQ;
      LSU_REQ: begin
        if (mem_gnt) begin
          if (r_we || mem_rvalid) w_state_next = LSU_IDLE;
          else                    w_state_next = LSU_RESP;
        end
      end
      LSU_RESP: if (mem_rvalid) w_state_next = LSU_IDLE;
      default:  w_state_next = LSU_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == LSU_IDLE);
    mem_req  = (r_state == LSU_REQ);
    stall    = (r_state != LSU_IDLE) || in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= 4'b0000;
      r_wdata    <= 32'h0;
      r_off      <= 2'b00;
      r_funct3   <= 3'b000;
      r_rd       <= 5'd0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= 32'h0;
    end else begin
      r_wb_valid <= w_capture;
      if (w_capture) begin
        r_wb_data <= w_ext;
        r_wb_rd   <= r_rd;
      end
      if (w_issue) begin
        r_we     <= in_we;
        r_addr   <= {in_addr[ADDR_W-1:2], 2'b00};
        r_be     <= lsu_be(in_funct3, w_off);
        r_wdata  <= w_wdata_rep;
        r_off    <= w_off;
        r_funct3 <= in_funct3;
        r_rd     <= in_rd;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic              r_exc;
  logic [ADDR_W-1:0] r_exc_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exc      <= 1'b0;
      r_exc_addr <= '0;
    end else begin
      r_exc <= w_accept && w_misalign;
      if (w_accept && w_misalign) r_exc_addr <= in_addr;
    end
  end

  assign misalign_exc  = r_exc;
  assign misalign_addr = r_exc_addr;
`endif

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;
  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;

endmodule
